uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//  Serial UART receiver. Runs on the 16x-oversampled uart clock. Recovers
//  8N1/8E1/8O1 frames from the rx pin and presents each byte with a strobe
//  and parity/stop-bit error flags. Feeds the ASCII-hex-to-fixed-point
//  assembler directly downstream. That stage rising-edge-detects rdsig
//  through two flops and clears itself while dataerror or frameerror is high.
// PARAMETERS
//  OVERSAMPLE  16  clk cycles per bit; even, >=8
//  PARITY_EN   1   1: a parity bit follows D7; 0: no parity bit
//  PARITY_ODD  0   0: even parity; 1: odd parity (ignored when PARITY_EN=0)
//  RDSIG_LEN   4   cycles rdsig stays high per frame; >=3
// PORTS
//  clk         in   1  uart oversample clock
//  rst         in   1  asynchronous, active-high reset
//  rx          in   1  serial line, idle high, asynchronous to clk
//  dataout     out  8  last received byte, LSB received first
//  rdsig       out  1  byte-ready strobe, high for RDSIG_LEN cycles
//  dataerror   out  1  parity mismatch on last frame
//  frameerror  out  1  stop bit sampled low on last frame
// BEHAVIOUR
//  Reset: dataout=0, rdsig=0, dataerror=0, frameerror=0, state=IDLE,
//   both sync flops=1, all counters=0. Reset mid-frame discards the frame.
//  rx passes through a 2-flop synchronizer (rx_s). All sampling uses rx_s.
//  tick counter: width clog2(OVERSAMPLE). bit counter: 3 bits.
//  FSM:
//   IDLE   : rx_s==0 -> START, tick=0.
//   START  : tick++. At tick==OVERSAMPLE/2-1: if rx_s==0 -> DATA, tick=0,
//            bit=0, clear dataerror and frameerror; else -> IDLE (glitch).
//   DATA   : tick++. At tick==OVERSAMPLE-1: shift[bit]=rx_s, tick=0.
//            After bit==7: -> PARITY if PARITY_EN, else -> STOP.
//   PARITY : at tick==OVERSAMPLE-1: perr = ^shift ^ rx_s ^ PARITY_ODD.
//            -> STOP.
//   STOP   : at tick==OVERSAMPLE-1: dataout<=shift, dataerror<=perr
//            (0 if !PARITY_EN), frameerror<=~rx_s, start rdsig.
//            -> IDLE if rx_s==1, else -> BREAK.
//   BREAK  : wait until rx_s==1, then -> IDLE. No frame is detected
//            while the line stays low.
//  Centre sampling: each bit is sampled OVERSAMPLE cycles after the
//   previous sample. The first sample is at the start-bit centre.
//  rdsig: registered. Rises one cycle after the STOP sample and stays high
//   exactly RDSIG_LEN cycles. It also asserts on error frames.
//  Latency from the first clk edge at which rx is low to rdsig rising:
//   2 + OVERSAMPLE/2 + OVERSAMPLE*(9+PARITY_EN) cycles (170 at defaults).
//  dataout, dataerror and frameerror are set together at the STOP sample.
//   dataout holds until the next STOP sample. The error flags hold until
//   the next confirmed start bit, so the downstream stage sees them level.
//  A new start bit during the rdsig window is accepted. The rdsig count
//   runs on independently.
//  Line timing and bit counts are fixed. Accumulated drift up to
//   +/-OVERSAMPLE/4 cycles over a frame is tolerated.
// TESTING
//  1 Defaults. Send 0x41, even parity bit 0, stop 1 -> dataout=8'h41;
//    rdsig high 4 cycles, rising 170 cycles after the rx fall; both error
//    flags 0.
//  2 Send 0x33 with parity bit forced to 1 -> dataout=8'h33, dataerror=1,
//    frameerror=0. The next good frame 0x30 clears dataerror at its
//    start-bit centre.
//  3 Send 0x46 with stop bit 0, then hold rx low 40 bit times -> frameerror=1;
//    no further rdsig until rx returns high and a new frame is sent.
//  4 Low glitch on rx of 5 cycles while IDLE -> back to IDLE; rdsig stays
//    0; dataout unchanged.
//  5 Eight back-to-back frames "3F800000" with one stop bit each -> eight
//    rdsig pulses with dataout sequence 33,46,38,30,30,30,30,30.
//  6 Assert rst during DATA bit 4 of a frame -> all outputs 0 the same
//    cycle. The next full frame 0x61 is received correctly.

Source files
------------

// File: rtl/uart_rx_frame_if.sv
// Serial-line side of the UART receiver: rx input plus the received byte,
// its strobe and its error flags.
interface uart_rx_frame_if;
    logic       rx;
    logic [7:0] dataout;
    logic       rdsig;
    logic       dataerror;
    logic       frameerror;

    modport master (output rx, input dataout, rdsig, dataerror, frameerror);
    modport slave  (input rx, output dataout, rdsig, dataerror, frameerror);
endinterface

// File: rtl/uart_rx_frame.sv
// 8N1/8E1/8O1 UART receiver on a 16x (OVERSAMPLE) clock with centre sampling,
// a parity/stop-bit error report and a fixed-length byte-ready strobe.
module uart_rx_frame #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned RDSIG_LEN  = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_frame_if.slave  bus
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned RD_W   = $clog2(RDSIG_LEN);

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [RD_W-1:0]   RD_LAST   = RD_W'(RDSIG_LEN - 1);
    localparam logic              PAR_EN_B  = (PARITY_EN != 0);
    localparam logic              PAR_ODD_B = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              perr_q, perr_d;
    logic [7:0]        dataout_q, dataout_d;
    logic              rdsig_q, rdsig_d;
    logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic              dataerror_q, dataerror_d;
    logic              frameerror_q, frameerror_d;
    logic              rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync_q       <= 2'b11;
            tick_q       <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            dataout_q    <= '0;
            rdsig_q      <= 1'b0;
            rd_cnt_q     <= '0;
            dataerror_q  <= 1'b0;
            frameerror_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            tick_q       <= tick_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            dataout_q    <= dataout_d;
            rdsig_q      <= rdsig_d;
            rd_cnt_q     <= rd_cnt_d;
            dataerror_q  <= dataerror_d;
            frameerror_q <= frameerror_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sync_d       = {sync_q[0], bus.rx};
        tick_d       = tick_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        dataout_d    = dataout_q;
        rdsig_d      = rdsig_q;
        rd_cnt_d     = rd_cnt_q;
        dataerror_d  = dataerror_q;
        frameerror_d = frameerror_q;

        // Strobe length counts down independently of the frame FSM.
        if (rdsig_q) begin
            if (rd_cnt_q == '0) begin
                rdsig_d = 1'b0;
            end else begin
                rd_cnt_d = rd_cnt_q - RD_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick_q == TICK_HALF) begin
                    tick_d = '0;
                    if (!rx_s) begin
                        state_d      = S_DATA;
                        bit_cnt_d    = '0;
                        dataerror_d  = 1'b0;
                        frameerror_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_DATA: begin
                if (tick_q == TICK_LAST) begin
                    tick_d             = '0;
                    shift_d[bit_cnt_q] = rx_s;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PAR_EN_B ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_PARITY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    perr_d  = (^shift_q) ^ rx_s ^ PAR_ODD_B;
                    state_d = S_STOP;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_STOP: begin
                if (tick_q == TICK_LAST) begin
                    tick_d       = '0;
                    dataout_d    = shift_q;
                    dataerror_d  = PAR_EN_B & perr_q;
                    frameerror_d = ~rx_s;
                    rdsig_d      = 1'b1;
                    rd_cnt_d     = RD_LAST;
                    state_d      = rx_s ? S_IDLE : S_BREAK;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_BREAK: begin
                // A held-low line is not a start bit; wait for it to go idle.
                tick_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    assign bus.dataout    = dataout_q;
    assign bus.rdsig      = rdsig_q;
    assign bus.dataerror  = dataerror_q;
    assign bus.frameerror = frameerror_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: frame-level scoreboard of expected output timing
// compared every cycle, plus directed literal checks and random frames.
module tb_uart_rx_frame;

    localparam int OS        = 16;
    localparam int PE        = 1;
    localparam int PO        = 0;
    localparam int RL        = 4;
    localparam int CLR_DLY   = 2 + OS / 2;
    localparam int DONE_DLY  = 2 + OS / 2 + OS * (9 + PE);
    localparam logic PO_B    = (PO != 0);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_frame_if bus ();

    uart_rx_frame #(
        .OVERSAMPLE (OS),
        .PARITY_EN  (PE),
        .PARITY_ODD (PO),
        .RDSIG_LEN  (RL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Frame-level model: each sent frame schedules a flag clear at its start
    // centre and a result/strobe event at its stop sample.
    typedef struct {
        int         cyc;
        bit         done;
        logic [7:0] data;
        logic       derr;
        logic       ferr;
    } ev_t;

    ev_t        evq[$];
    ev_t        cur_ev;
    logic [7:0] exp_data = 8'h00;
    logic       exp_derr = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_rdsig;
    int         rd_start = -1000;
    bit         chk_en   = 1'b0;

    task automatic model_reset();
        evq.delete();
        exp_data = 8'h00;
        exp_derr = 1'b0;
        exp_ferr = 1'b0;
        rd_start = -1000;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            while (evq.size() > 0 && evq[0].cyc <= edge_n) begin
                cur_ev = evq.pop_front();
                if (cur_ev.done) begin
                    exp_data = cur_ev.data;
                    exp_derr = cur_ev.derr;
                    exp_ferr = cur_ev.ferr;
                    rd_start = cur_ev.cyc;
                end else begin
                    exp_derr = 1'b0;
                    exp_ferr = 1'b0;
                end
            end
            exp_rdsig = (edge_n >= rd_start) && (edge_n < rd_start + RL);
            check("rdsig",      32'(bus.rdsig),      32'(exp_rdsig));
            check("dataout",    32'(bus.dataout),    32'(exp_data));
            check("dataerror",  32'(bus.dataerror),  32'(exp_derr));
            check("frameerror", 32'(bus.frameerror), 32'(exp_ferr));
        end
    end

    // Strobe monitor: counts pulses, logs byte at each rise, measures width.
    int         pulses    = 0;
    int         rise_edge = -1;
    int         cur_len   = 0;
    int         last_len  = 0;
    logic       prev_rd   = 1'b0;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        if (bus.rdsig && !prev_rd) begin
            pulses++;
            rise_edge = edge_n;
            cur_len   = 1;
            rx_log.push_back(bus.dataout);
        end else if (bus.rdsig) begin
            cur_len++;
        end else if (prev_rd) begin
            last_len = cur_len;
        end
        prev_rd = bus.rdsig;
    end

    task automatic hold(input logic v, input int n);
        if (n > 0) begin
            bus.rx = v;
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_v,
                              output int c0);
        logic p;
        ev_t  e;
        p  = (^b) ^ PO_B ^ bad_par;
        c0 = edge_n + 1;
        e.cyc  = c0 + CLR_DLY;
        e.done = 1'b0;
        e.data = 8'h00;
        e.derr = 1'b0;
        e.ferr = 1'b0;
        evq.push_back(e);
        e.cyc  = c0 + DONE_DLY;
        e.done = 1'b1;
        e.data = b;
        e.derr = (PE != 0) && bad_par;
        e.ferr = !stop_v;
        evq.push_back(e);
        hold(1'b0, OS);
        for (int i = 0; i < 8; i++) hold(b[i], OS);
        if (PE != 0) hold(p, OS);
        hold(stop_v, OS);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1);
    end

    initial begin
        int         c0;
        int         p0;
        int         n0;
        logic [7:0] b;
        bit         bp;
        bit         sv;
        logic [7:0] seq [8];

        seq = '{8'h33, 8'h46, 8'h38, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30};
        rst    = 1'b1;
        bus.rx = 1'b1;
        model_reset();
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dataout",    32'(bus.dataout),    32'h0);
        check("reset_rdsig",      32'(bus.rdsig),      32'h0);
        check("reset_dataerror",  32'(bus.dataerror),  32'h0);
        check("reset_frameerror", 32'(bus.frameerror), 32'h0);
        rst = 1'b0;
        hold(1'b1, 10);

        // 1: clean 0x41, latency and strobe width
        send_frame(8'h41, 1'b0, 1'b1, c0);
        hold(1'b1, 8);
        check("t1_latency",   32'(rise_edge - c0), 32'd170);
        check("t1_width",     32'(last_len),       32'd4);
        check("t1_dataout",   32'(bus.dataout),    32'h41);
        check("t1_dataerror", 32'(bus.dataerror),  32'h0);
        check("t1_frameerr",  32'(bus.frameerror), 32'h0);

        // 2: parity error on 0x33, cleared at next start-bit centre
        send_frame(8'h33, 1'b1, 1'b1, c0);
        hold(1'b1, 4);
        check("t2_dataout",   32'(bus.dataout),    32'h33);
        check("t2_dataerror", 32'(bus.dataerror),  32'h1);
        check("t2_frameerr",  32'(bus.frameerror), 32'h0);
        c0 = edge_n + 1;
        fork
            send_frame(8'h30, 1'b0, 1'b1, n0);
            begin
                repeat (10) @(posedge clk);
                #1;
                check("t2_derr_before_centre", 32'(bus.dataerror), 32'h1);
                @(posedge clk);
                #1;
                check("t2_derr_at_centre", 32'(bus.dataerror), 32'h0);
            end
        join
        hold(1'b1, 4);
        check("t2_next_dataout", 32'(bus.dataout), 32'h30);

        // 3: stop bit low then line held low 40 bit times
        p0 = pulses;
        send_frame(8'h46, 1'b0, 1'b0, c0);
        hold(1'b0, 40 * OS);
        check("t3_frameerr", 32'(bus.frameerror), 32'h1);
        check("t3_dataout",  32'(bus.dataout),    32'h46);
        check("t3_pulses",   32'(pulses - p0),    32'd1);
        hold(1'b1, 20);
        send_frame(8'h55, 1'b0, 1'b1, c0);
        hold(1'b1, 4);
        check("t3_recover_pulses",   32'(pulses - p0),    32'd2);
        check("t3_recover_dataout",  32'(bus.dataout),    32'h55);
        check("t3_recover_frameerr", 32'(bus.frameerror), 32'h0);

        // 4: 5-cycle low glitch while idle
        p0 = pulses;
        hold(1'b0, 5);
        hold(1'b1, 40);
        check("t4_pulses",  32'(pulses - p0),    32'd0);
        check("t4_dataout", 32'(bus.dataout),    32'h55);
        check("t4_frameerr", 32'(bus.frameerror), 32'h0);

        // 5: eight back-to-back frames "3F800000"
        n0 = rx_log.size();
        for (int i = 0; i < 8; i++) send_frame(seq[i], 1'b0, 1'b1, c0);
        hold(1'b1, 10);
        check("t5_count", 32'(rx_log.size() - n0), 32'd8);
        if (rx_log.size() >= n0 + 8) begin
            for (int i = 0; i < 8; i++) check("t5_byte", 32'(rx_log[n0 + i]), 32'(seq[i]));
        end

        // 6: reset during data bit 4, then a clean 0x61
        b  = 8'h5A;
        c0 = edge_n + 1;
        cur_ev.cyc  = c0 + CLR_DLY;
        cur_ev.done = 1'b0;
        cur_ev.data = 8'h00;
        cur_ev.derr = 1'b0;
        cur_ev.ferr = 1'b0;
        evq.push_back(cur_ev);
        hold(1'b0, OS);
        for (int i = 0; i < 4; i++) hold(b[i], OS);
        hold(b[4], 8);
        rst    = 1'b1;
        bus.rx = 1'b1;
        model_reset();
        #1;
        check("t6_rst_dataout",    32'(bus.dataout),    32'h0);
        check("t6_rst_rdsig",      32'(bus.rdsig),      32'h0);
        check("t6_rst_dataerror",  32'(bus.dataerror),  32'h0);
        check("t6_rst_frameerror", 32'(bus.frameerror), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b1, 10);
        send_frame(8'h61, 1'b0, 1'b1, c0);
        hold(1'b1, 4);
        check("t6_dataout", 32'(bus.dataout), 32'h61);
        check("t6_latency", 32'(rise_edge - c0), 32'd170);

        // Random frames with occasional parity and stop-bit errors
        for (int k = 0; k < 40; k++) begin
            b  = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 5) == 0);
            sv = ($urandom_range(0, 7) != 0);
            send_frame(b, bp, sv, c0);
            check("rand_byte", 32'(rx_log[rx_log.size() - 1]), 32'(b));
            hold(1'b1, sv ? int'($urandom_range(0, 30)) : int'($urandom_range(2, 30)));
        end
        hold(1'b1, 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
